// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared RMII receive/transmit types and constants
package rmii_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;

  localparam logic [1:0]  PRE_DIBIT   = 2'b01;
  localparam logic [1:0]  SFD_DIBIT   = 2'b11;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/rmii_crc32_d2.sv
// rtl/rmii_crc32_d2.sv - combinational reflected CRC-32 step for one dibit (LSB first)
module rmii_crc32_d2
  import rmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  din,
  output logic [31:0] crc_next
);

  function automatic logic [31:0] step(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
  endfunction

  assign crc_next = step(step(crc, din[0]), din[1]);

endmodule

// File: rtl/rmii_rx_deframer.sv
// rtl/rmii_rx_deframer.sv - RMII receive deframer: preamble/SFD strip, dibit-to-byte, frame status
// Optional FCS checking is built when RMII_RX_CRC_EN is defined.
module rmii_rx_deframer
  import rmii_pkg::*;
#(
  parameter int MIN_PRE = 4,
  parameter int MAX_LEN = 1536,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_erxd,
  input  logic             i_erx_dv,
  input  logic             i_erx_er,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_err,
  output logic             o_crc_err,
  output logic [CNT_W-1:0] o_len
);

  localparam int PRE_W = $clog2(MIN_PRE + 1);

  logic [1:0]       rxd_q;
  logic             dv_q;
  logic             er_q;
  rx_state_t        state;
  rx_state_t        state_nx;
  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       phase;
  logic [5:0]       asm_q;
  logic [7:0]       hold;
  logic             hold_full;
  logic             first_pending;
  logic [CNT_W-1:0] byte_cnt;
  logic             ovf;
  logic             rx_err;
  logic             crc_bad;
  logic             frame_start;
  logic             data_dibit;
  logic             frame_end;
  logic             byte_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    data_dibit  = 1'b0;
    frame_end   = 1'b0;
    byte_done   = 1'b0;
    case (state)
      IDLE: if (dv_q) state_nx = (rxd_q == PRE_DIBIT) ? PRE : DROP;
      PRE: begin
        if (!dv_q)                   state_nx = IDLE;
        else if (rxd_q == PRE_DIBIT) state_nx = PRE;
        else if (rxd_q == SFD_DIBIT && pre_cnt >= PRE_W'(MIN_PRE)) begin
          state_nx    = DATA;
          frame_start = 1'b1;
        end
        else                         state_nx = DROP;
      end
      DATA: begin
        if (!dv_q) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end else begin
          data_dibit = 1'b1;
          byte_done  = (phase == 2'd3);
        end
      end
      DROP: if (!dv_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q         <= '0;
      dv_q          <= 1'b0;
      er_q          <= 1'b0;
      pre_cnt       <= '0;
      phase         <= '0;
      asm_q         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      first_pending <= 1'b0;
      byte_cnt      <= '0;
      ovf           <= 1'b0;
      rx_err        <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_sof         <= 1'b0;
      o_eof         <= 1'b0;
      o_err         <= 1'b0;
      o_crc_err     <= 1'b0;
      o_len         <= '0;
    end else begin
      rxd_q     <= i_erxd;
      dv_q      <= i_erx_dv;
      er_q      <= i_erx_er;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_err     <= 1'b0;
      o_crc_err <= 1'b0;
      o_len     <= '0;

      if (state == IDLE && dv_q && rxd_q == PRE_DIBIT)
        pre_cnt <= PRE_W'(1);
      else if (state == PRE && rxd_q == PRE_DIBIT && pre_cnt != PRE_W'(MIN_PRE))
        pre_cnt <= pre_cnt + PRE_W'(1);

      if (frame_start) begin
        phase         <= '0;
        hold_full     <= 1'b0;
        first_pending <= 1'b1;
        byte_cnt      <= '0;
        ovf           <= 1'b0;
        rx_err        <= 1'b0;
      end

      if (data_dibit) begin
        phase <= phase + 2'd1;
        if (er_q) rx_err <= 1'b1;
        case (phase)
          2'd0:    asm_q[1:0] <= rxd_q;
          2'd1:    asm_q[3:2] <= rxd_q;
          2'd2:    asm_q[5:4] <= rxd_q;
          default: ;
        endcase
      end

      // A completed byte waits in hold so the frame's last byte can carry eof.
      if (byte_done) begin
        if (byte_cnt < CNT_W'(MAX_LEN)) begin
          hold      <= {rxd_q, asm_q};
          hold_full <= 1'b1;
          byte_cnt  <= byte_cnt + CNT_W'(1);
          if (hold_full) begin
            o_valid       <= 1'b1;
            o_data        <= hold;
            o_sof         <= first_pending;
            first_pending <= 1'b0;
          end
        end else begin
          ovf <= 1'b1;
        end
      end

      if (frame_end) begin
        hold_full <= 1'b0;
        if (hold_full) begin
          o_valid   <= 1'b1;
          o_data    <= hold;
          o_sof     <= first_pending;
          o_eof     <= 1'b1;
          o_len     <= byte_cnt;
          o_err     <= rx_err | ovf | (phase != 2'd0) | crc_bad;
          o_crc_err <= crc_bad;
        end
      end
    end
  end

`ifdef RMII_RX_CRC_EN
  logic [31:0] crc;
  logic [31:0] crc_nx;

  rmii_crc32_d2 u_crc (
    .crc      (crc),
    .din      (rxd_q),
    .crc_next (crc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              crc <= CRC_INIT;
    else if (frame_start) crc <= CRC_INIT;
    else if (data_dibit)  crc <= crc_nx;
  end

  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

endmodule
